// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and bubble-inserting flush.
// Optional back-pressure stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 23,
  parameter int DATA_W = 174,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_m_valid;
  logic              r_s_valid;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] r_s_data;

  logic              w_accept;
  logic              w_drain;
  logic              w_m_valid_nxt;
  logic              w_s_valid_nxt;
  logic [CTRL_W-1:0] w_m_ctrl_nxt;
  logic [CTRL_W-1:0] w_s_ctrl_nxt;
  logic [DATA_W-1:0] w_m_data_nxt;
  logic [DATA_W-1:0] w_s_data_nxt;

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_drain  = r_m_valid & out_ready;

  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_s_valid_nxt = r_s_valid;
    w_m_ctrl_nxt  = r_m_ctrl;
    w_s_ctrl_nxt  = r_s_ctrl;
    w_m_data_nxt  = r_m_data;
    w_s_data_nxt  = r_s_data;
    if (flush) begin
      // data flops deliberately hold; only valids and control are killed
      w_m_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
      w_m_ctrl_nxt  = '0;
      w_s_ctrl_nxt  = '0;
    end else if (!r_m_valid || w_drain) begin
      if (r_s_valid) begin
        w_m_valid_nxt = 1'b1;
        w_m_ctrl_nxt  = r_s_ctrl;
        w_m_data_nxt  = r_s_data;
        w_s_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_m_valid_nxt = 1'b1;
        w_m_ctrl_nxt  = in_ctrl;
        w_m_data_nxt  = in_data;
      end else begin
        w_m_valid_nxt = 1'b0;
        w_m_ctrl_nxt  = '0;
      end
    end else if (w_accept) begin
      w_s_valid_nxt = 1'b1;
      w_s_ctrl_nxt  = in_ctrl;
      w_s_data_nxt  = in_data;
    end
  end

  // in_ready has its own flop so no path exists from out_ready to in_ready
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_m_ctrl   <= '0;
      r_s_ctrl   <= '0;
      r_m_data   <= '0;
      r_s_data   <= '0;
    end else begin
      r_m_valid  <= w_m_valid_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_in_ready <= ~w_s_valid_nxt;
      r_m_ctrl   <= w_m_ctrl_nxt;
      r_s_ctrl   <= w_s_ctrl_nxt;
      r_m_data   <= w_m_data_nxt;
      r_s_data   <= w_s_data_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_m_valid;
  assign out_ctrl  = r_m_valid ? r_m_ctrl : '0;
  assign out_data  = r_m_data;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // saturating; survives flush, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register, successor to the fixed-width ID/EX latch. Carries one control bundle (WB/MEM/EX fields) and one data bundle (PC+4, operands, immediate, register indices, jump target) between two pipeline stages. Adds what the fixed latch lacks:
- valid/ready handshake
- 2-entry skid buffer, giving full throughput under back-pressure
- synchronous flush that inserts a NOP bubble
Sits between decode and execute; other stage boundaries reuse it with different widths.

Parameters:
CTRL_W, 23, control bundle width (default = WB 3 + MEM 12 + EX 8); forced to 0 on bubble/flush
DATA_W, 174, data bundle width (default = 4x32 + 4x5 + 26); not cleared on flush
CNT_W, 16, width of the stall counter (optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
flush  input  1  drop all held entries; takes effect at the next edge
in_valid  input  1  upstream presents an entry
in_ready  output  1  stage can accept an entry this cycle
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  entry available to downstream
out_ready  input  1  downstream consumes this cycle
out_ctrl  output  CTRL_W  registered control bundle; all-zero when out_valid=0
out_data  output  DATA_W  registered data bundle
stall_cnt  output  CNT_W  back-pressure cycle count (see Optional Feature)

Behaviour:
- State: main entry (m_valid, m_ctrl, m_data) and skid entry (s_valid, s_ctrl, s_data).
- Outputs:
  - out_valid = m_valid; out_data = m_data.
  - out_ctrl = m_valid ? m_ctrl : 0.
  - in_ready = ~s_valid, driven directly from a flop with no combinational path from out_ready.
- Events, evaluated at each rising edge:
  - accept = in_valid & in_ready & reset & ~flush.
  - drain = m_valid & out_ready.
- Reset (reset==0 at edge): m_valid, s_valid, m_ctrl, s_ctrl, m_data, s_data all cleared to 0. After reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0. Reset overrides flush and handshake.
- Flush (reset==1, flush==1): m_valid=0, s_valid=0, m_ctrl=0, s_ctrl=0. Data flops hold. Any entry offered that cycle is dropped even if in_ready=1. Next cycle: in_ready=1, out_valid=0.
- Normal operation, first matching case applies:
  - main empty or drain, and s_valid: main <= skid; s_valid<=0. If accept is also true, the new entry goes to main... Correction: in this case in_ready was 0, so accept cannot occur.
  - main empty or drain, no skid: main <= input if accept, else m_valid<=0 and m_ctrl<=0.
  - main full, no drain, accept: skid <= input; s_valid<=1, so in_ready drops next cycle.
  - otherwise: hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO. No entry is lost or duplicated outside flush.
- Capacity: max 2 entries.
  - Full (2 entries, in_ready=0) with out_ready=1: skid moves to main. in_ready=1 the following cycle.
- out_valid never drops without drain, flush or reset. out_data/out_ctrl are stable while out_valid=1 and out_ready=0.
- Widths: no arithmetic on payload. Payload is passed bit-exact.

Optional Feature:
Macro PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset; flush does not clear it.
- Undefined: stall_cnt is tied to 0 and no counter flops exist. The port is present in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0; nothing accepted.
- Streaming: out_ready=1, send ctrl=0x00001..0x00005 on 5 consecutive cycles -> each appears exactly 1 cycle later, in order, in_ready held at 1.
- Back-pressure: out_ready=0, offer A (ctrl=0x11) then B (ctrl=0x22) -> both accepted, in_ready=0 next cycle, C held off, out_ctrl stays 0x11. Raise out_ready -> A, B, C emerge in order, no gaps after the skid drains.
- Flush with full skid: two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the offered entry never appears.
- Reset mid-stall: skid full, out_ready=0, reset=0 for 1 cycle -> all valids 0, in_ready=1; stall_cnt returns to 0.
- Counter (PIPE_STALL_CNT_EN, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 and stays. Without the macro -> stall_cnt=0 throughout.
